// File: rtl/uart_pkg.sv
// Shared types for the configurable UART transmitter: FSM states, parity modes and parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    ODD  = 2'd1,
    EVEN = 2'd2,
    RSVD = 2'd3
  } parity_e;

  localparam int MAX_FRAME_BITS = 12;

  // Zero padding above the payload leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [MAX_FRAME_BITS-1:0] data, input parity_e mode);
    return (mode == ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..N-1 while enabled (N = max(period,1)), ticks on the last clock.
// Combinational tick from the count register; no backpressure.
module uart_baud_cnt #(
  parameter int DIV_W = 16
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_Enable,
  input  logic [DIV_W-1:0] i_Period,
  output logic             o_Tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] last_cnt;

  always_comb begin
    last_cnt = (i_Period > DIV_W'(1)) ? (i_Period - DIV_W'(1)) : '0;
    o_Tick   = i_Enable && (cnt_q == last_cnt);
    cnt_d    = cnt_q;
    if (!i_Enable || o_Tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with per-frame divisor, parity and stop-bit config latched at acceptance.
// Line goes low one cycle after the accepting edge; o_Tx_Ready only in IDLE, so valid may be held.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 16
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic [DIV_W-1:0]     i_Clks_Per_Bit,
  input  logic [1:0]           i_Parity_Mode,
  input  logic                 i_Two_Stop,
  input  logic                 i_Tx_Valid,
  input  logic [DATA_BITS-1:0] i_Tx_Data,
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Done
);

  localparam int IDX_W = $clog2(DATA_BITS);

  tx_state_e            state_q,   state_d;
  logic [DATA_BITS-1:0] shift_q,   shift_d;
  logic [IDX_W-1:0]     idx_q,     idx_d;
  logic [DIV_W-1:0]     div_q,     div_d;
  logic                 par_en_q,  par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 two_q,     two_d;
  logic                 stop2_q,   stop2_d;
  logic                 tx_q,      tx_d;
  logic                 done_q,    done_d;

  logic                      tick;
  parity_e                   mode_in;
  logic [MAX_FRAME_BITS-1:0] data_ext;

  assign mode_in  = parity_e'(i_Parity_Mode);
  assign data_ext = MAX_FRAME_BITS'(i_Tx_Data);

  uart_baud_cnt #(
    .DIV_W(DIV_W)
  ) u_baud (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Enable(state_q != ST_IDLE),
    .i_Period(div_q),
    .o_Tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    div_d     = div_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    two_d     = two_q;
    stop2_d   = stop2_q;
    tx_d      = tx_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (i_Tx_Valid) begin
          state_d   = ST_START;
          tx_d      = 1'b0;
          shift_d   = i_Tx_Data;
          idx_d     = '0;
          div_d     = i_Clks_Per_Bit;
          par_en_d  = (mode_in == ODD) || (mode_in == EVEN);
          par_bit_d = parity_bit(data_ext, mode_in);
          two_d     = i_Two_Stop;
          stop2_d   = 1'b0;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            if (par_en_q) begin
              state_d = ST_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
      ST_STOP: begin
        if (tick) begin
          // First of two stop periods: stay in STOP with the line high.
          if (two_q && !stop2_q) begin
            stop2_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      idx_q     <= '0;
      div_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      two_q     <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      div_q     <= div_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      two_q     <= two_d;
      stop2_q   <= stop2_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  assign o_Tx_Ready  = (state_q == ST_IDLE);
  assign o_Tx_Active = (state_q != ST_IDLE);
  assign o_Tx_Serial = tx_q;
  assign o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: table of frames with hand-computed line patterns,
// plus back-to-back, mid-frame reset and reset-state sequences.
module tb_uart_tx_cfg;

  logic        i_Clock;
  logic        i_Reset;
  logic [15:0] i_Clks_Per_Bit;
  logic [1:0]  i_Parity_Mode;
  logic        i_Two_Stop;
  logic        i_Tx_Valid;
  logic [7:0]  i_Tx_Data;
  logic        o_Tx_Ready;
  logic        o_Tx_Active;
  logic        o_Tx_Serial;
  logic        o_Tx_Done;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_cfg #(
    .DATA_BITS(8),
    .DIV_W    (16)
  ) dut (
    .i_Clock       (i_Clock),
    .i_Reset       (i_Reset),
    .i_Clks_Per_Bit(i_Clks_Per_Bit),
    .i_Parity_Mode (i_Parity_Mode),
    .i_Two_Stop    (i_Two_Stop),
    .i_Tx_Valid    (i_Tx_Valid),
    .i_Tx_Data     (i_Tx_Data),
    .o_Tx_Ready    (o_Tx_Ready),
    .o_Tx_Active   (o_Tx_Active),
    .o_Tx_Serial   (o_Tx_Serial),
    .o_Tx_Done     (o_Tx_Done)
  );

  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // line[k] is the k-th bit on the wire (bit 0 = start bit).
  typedef struct {
    logic [15:0] div;
    logic [1:0]  par;
    logic        two;
    logic [7:0]  data;
    int          n_eff;
    int          nbits;
    logic [12:0] line;
    logic        scramble;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send_vec(input vec_t v, input int id);
    int  cyc;
    int  bi;
    bit  got_done;
    logic exp_bit;
    i_Clks_Per_Bit = v.div;
    i_Parity_Mode  = v.par;
    i_Two_Stop     = v.two;
    i_Tx_Data      = v.data;
    i_Tx_Valid     = 1'b1;
    chk($sformatf("v%0d_pre_ready", id), int'(o_Tx_Ready), 1);
    @(posedge i_Clock);
    #1 i_Tx_Valid = 1'b0;
    cyc      = 0;
    got_done = 0;
    while (!got_done && cyc < 200) begin
      @(negedge i_Clock);
      if (v.scramble && cyc == 5) begin
        i_Clks_Per_Bit = 16'd9;
        i_Parity_Mode  = 2'd2;
        i_Two_Stop     = 1'b1;
        i_Tx_Data      = ~v.data;
      end
      if (o_Tx_Done) begin
        got_done = 1;
        chk($sformatf("v%0d_frame_len", id), cyc, v.nbits * v.n_eff);
        chk($sformatf("v%0d_end_line", id), int'(o_Tx_Serial), 1);
        chk($sformatf("v%0d_end_ready", id), int'(o_Tx_Ready), 1);
        chk($sformatf("v%0d_end_active", id), int'(o_Tx_Active), 0);
      end else begin
        bi      = cyc / v.n_eff;
        exp_bit = (bi < v.nbits) ? v.line[bi] : 1'b1;
        chk($sformatf("v%0d_line_c%0d", id, cyc), int'(o_Tx_Serial), int'(exp_bit));
        chk($sformatf("v%0d_active_c%0d", id, cyc), int'(o_Tx_Active), 1);
        chk($sformatf("v%0d_busy_ready_c%0d", id, cyc), int'(o_Tx_Ready), 0);
        cyc++;
      end
    end
    chk($sformatf("v%0d_done_seen", id), int'(got_done), 1);
    @(negedge i_Clock);
    chk($sformatf("v%0d_done_pulse_1cyc", id), int'(o_Tx_Done), 0);
  endtask

  initial begin
    logic [9:0] f1;
    logic [9:0] f2;
    int         cyc;
    logic       exp_bit;
    bit         gap;

    vecs[0]  = '{div:16'd4, par:2'd0, two:1'b0, data:8'hA5, n_eff:4, nbits:10, line:13'b000_1101001010,  scramble:1'b0};
    vecs[1]  = '{div:16'd3, par:2'd2, two:1'b1, data:8'h07, n_eff:3, nbits:12, line:13'b0_111000001110,  scramble:1'b0};
    vecs[2]  = '{div:16'd3, par:2'd1, two:1'b1, data:8'h07, n_eff:3, nbits:12, line:13'b0_110000001110,  scramble:1'b0};
    vecs[3]  = '{div:16'd0, par:2'd0, two:1'b0, data:8'h3C, n_eff:1, nbits:10, line:13'b000_1001111000,  scramble:1'b0};
    vecs[4]  = '{div:16'd1, par:2'd0, two:1'b0, data:8'h3C, n_eff:1, nbits:10, line:13'b000_1001111000,  scramble:1'b0};
    vecs[5]  = '{div:16'd2, par:2'd3, two:1'b0, data:8'h81, n_eff:2, nbits:10, line:13'b000_1100000010,  scramble:1'b0};
    vecs[6]  = '{div:16'd2, par:2'd1, two:1'b0, data:8'h00, n_eff:2, nbits:11, line:13'b00_11000000000, scramble:1'b0};
    vecs[7]  = '{div:16'd1, par:2'd2, two:1'b0, data:8'hFF, n_eff:1, nbits:11, line:13'b00_10111111110, scramble:1'b0};
    vecs[8]  = '{div:16'd5, par:2'd0, two:1'b1, data:8'h55, n_eff:5, nbits:11, line:13'b00_11010101010, scramble:1'b0};
    vecs[9]  = '{div:16'd4, par:2'd0, two:1'b0, data:8'hA5, n_eff:4, nbits:10, line:13'b000_1101001010,  scramble:1'b1};
    vecs[10] = '{div:16'd9, par:2'd0, two:1'b0, data:8'h0F, n_eff:9, nbits:10, line:13'b000_1000011110,  scramble:1'b0};

    // Reset with valid held high: reset must win.
    i_Reset        = 1'b1;
    i_Clks_Per_Bit = 16'd1;
    i_Parity_Mode  = 2'd0;
    i_Two_Stop     = 1'b0;
    i_Tx_Valid     = 1'b1;
    i_Tx_Data      = 8'hFF;
    repeat (2) @(posedge i_Clock);
    @(negedge i_Clock);
    chk("rst_serial", int'(o_Tx_Serial), 1);
    chk("rst_ready", int'(o_Tx_Ready), 1);
    chk("rst_active", int'(o_Tx_Active), 0);
    chk("rst_done", int'(o_Tx_Done), 0);
    i_Tx_Valid = 1'b0;
    i_Reset    = 1'b0;
    @(negedge i_Clock);
    chk("post_rst_idle_line", int'(o_Tx_Serial), 1);

    for (int i = 0; i < 11; i++) begin
      send_vec(vecs[i], i);
    end

    // Back-to-back with valid held: 0x11 then 0x22 at N=2, one idle-high gap.
    f1 = 10'b1000100010;
    f2 = 10'b1001000100;
    i_Clks_Per_Bit = 16'd2;
    i_Parity_Mode  = 2'd0;
    i_Two_Stop     = 1'b0;
    i_Tx_Data      = 8'h11;
    i_Tx_Valid     = 1'b1;
    @(posedge i_Clock);
    #1 i_Tx_Data = 8'h22;
    for (int c = 0; c < 42; c++) begin
      @(negedge i_Clock);
      gap = (c == 20) || (c == 41);
      if (c < 20)       exp_bit = f1[c / 2];
      else if (gap)     exp_bit = 1'b1;
      else              exp_bit = f2[(c - 21) / 2];
      chk($sformatf("b2b_line_c%0d", c), int'(o_Tx_Serial), int'(exp_bit));
      chk($sformatf("b2b_ready_c%0d", c), int'(o_Tx_Ready), int'(gap));
      chk($sformatf("b2b_done_c%0d", c), int'(o_Tx_Done), int'(gap));
      if (c == 20) begin
        @(posedge i_Clock);
        #1 i_Tx_Valid = 1'b0;
      end
    end

    // Reset during data bit 3 at N=5, then immediate new acceptance.
    @(negedge i_Clock);
    i_Clks_Per_Bit = 16'd5;
    i_Tx_Data      = 8'h00;
    i_Tx_Valid     = 1'b1;
    @(posedge i_Clock);
    #1 i_Tx_Valid = 1'b0;
    for (int c = 0; c < 21; c++) @(negedge i_Clock);
    chk("mid_before_rst_line", int'(o_Tx_Serial), 0);
    i_Reset = 1'b1;
    @(posedge i_Clock);
    @(negedge i_Clock);
    chk("mid_rst_line", int'(o_Tx_Serial), 1);
    chk("mid_rst_done", int'(o_Tx_Done), 0);
    chk("mid_rst_active", int'(o_Tx_Active), 0);
    chk("mid_rst_ready", int'(o_Tx_Ready), 1);
    i_Reset    = 1'b0;
    i_Tx_Data  = 8'h5A;
    i_Tx_Valid = 1'b1;
    @(posedge i_Clock);
    #1 i_Tx_Valid = 1'b0;
    @(negedge i_Clock);
    chk("after_rst_start_line", int'(o_Tx_Serial), 0);
    chk("after_rst_active", int'(o_Tx_Active), 1);
    cyc = 1;
    while (cyc < 200) begin
      @(negedge i_Clock);
      if (o_Tx_Done) break;
      cyc++;
    end
    chk("after_rst_frame_len", cyc, 50);
    chk("after_rst_done", int'(o_Tx_Done), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 Parameter DATA_BITS, default 8, SHALL set the data bits per frame; legal range 5..9.
REQ-002 Parameter DIV_W, default 16, SHALL set the width of the runtime bit-period divisor.
REQ-003 i_Clock  in  1  SHALL be the single clock; all logic is on its rising edge.
REQ-004 i_Reset  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 i_Clks_Per_Bit  in  DIV_W  SHALL give the clocks per bit; 0 and 1 both mean 1.
REQ-006 i_Parity_Mode  in  2  SHALL select parity: 0 none, 1 odd, 2 even, 3 treated as none.
REQ-007 i_Two_Stop  in  1  SHALL select the stop bits: 1 = two, 0 = one.
REQ-008 i_Tx_Valid  in  1  SHALL request transmission of i_Tx_Data.
REQ-009 i_Tx_Data  in  DATA_BITS  SHALL carry the payload, sent LSB first.
REQ-010 o_Tx_Ready  out  1  SHALL indicate the block accepts a word this cycle.
REQ-011 o_Tx_Active  out  1  SHALL be high while a frame is on the line.
REQ-012 o_Tx_Serial  out  1  SHALL be the registered serial line, idle high.
REQ-013 o_Tx_Done  out  1  SHALL pulse for one cycle at frame end.

Function
REQ-014 Transfer SHALL occur on a rising edge with i_Tx_Valid=1 and o_Tx_Ready=1; the data and all three config inputs are latched together at that edge.
- Config changes mid-frame SHALL have no effect on the frame in flight.
REQ-015 o_Tx_Ready SHALL be high only in IDLE.
- i_Tx_Valid may be held high; no word is lost or duplicated.
REQ-016 State machine SHALL be IDLE -> START -> DATA -> PARITY (skipped when parity is none) -> STOP -> IDLE.
- STOP lasts one bit period, or two when two stop bits were latched.
REQ-017 Each bit SHALL last exactly N clocks, N = max(latched divisor, 1); the counter runs 0..N-1 and then wraps to 0.
REQ-018 START SHALL drive 0; DATA bit i SHALL drive latched data[i], i = 0..DATA_BITS-1; STOP SHALL drive 1.
REQ-019 The parity bit SHALL be computed over the latched data bits only.
- odd: XOR of the bits, inverted.
- even: XOR of the bits.
REQ-020 o_Tx_Serial SHALL go low in the cycle after the accepting edge.
- Frame length SHALL be (1 + DATA_BITS + P + S) * N clocks; P = 0 or 1 parity bits, S = 1 or 2 stop bits.
REQ-021 o_Tx_Active SHALL rise in the cycle after acceptance and fall in the cycle after the last stop clock.
- o_Tx_Done and o_Tx_Ready SHALL be high in that same cycle.
REQ-022 Back-to-back SHALL be supported: with i_Tx_Valid held high, the next start bit follows the last stop clock with exactly one idle-high clock.
REQ-023 Illegal state encodings SHALL return to IDLE on the next edge, with o_Tx_Serial=1.

Reset
REQ-024 With i_Reset=1 at an edge, outputs SHALL become o_Tx_Serial=1, o_Tx_Ready=1, o_Tx_Active=0, o_Tx_Done=0; state SHALL become IDLE; counters and the shift register SHALL be 0.
REQ-025 Reset mid-frame SHALL abort the frame with no o_Tx_Done pulse; the line is high from the next cycle.
REQ-026 Reset SHALL take priority over a simultaneous i_Tx_Valid.

Structure
REQ-027 Package uart_pkg SHALL hold:
- the state enum;
- the parity-mode enum (NONE, ODD, EVEN, RSVD);
- the localparam MAX_FRAME_BITS = 12.
REQ-028 The bit-period counter SHALL be a sub-module uart_baud_cnt with:
- inputs: clock, reset, enable, period;
- output: 1-cycle tick on the last clock of each bit.

Verification
REQ-029 Config N=4, 8N1, data 0xA5 -> line 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks, 40 clocks total; one o_Tx_Done pulse.
REQ-030 Config N=3, even parity, two stop bits, data 0x07 -> parity bit 1, frame 12 bits = 36 clocks; with odd parity the parity bit is 0.
REQ-031 Divisor 0 and divisor 1 -> identical 10-clock 8N1 frames.
REQ-032 i_Tx_Valid held with data 0x11 then 0x22, N=2 -> two frames separated by exactly one idle clock; o_Tx_Ready high only in the gap cycles.
REQ-033 i_Reset asserted during data bit 3, N=5 -> o_Tx_Serial=1 next cycle, no o_Tx_Done; a new word is accepted on the first cycle after reset deasserts.
REQ-034 i_Clks_Per_Bit changed from 4 to 9 mid-frame -> current frame stays at 4 clocks per bit; next frame uses 9.
